// File: rtl/bus_arbiter_rr_if.sv
// Bus bundle between the round-robin arbiter, its requesting channels and
// the memory/busio side. The arbiter uses the master view.
interface bus_arbiter_rr_if #(
  parameter int NCHAN = 2
);
  logic [NCHAN-1:0]   req;
  logic [4*NCHAN-1:0] op;
  logic [NCHAN-1:0]   grant;
  logic [NCHAN-1:0]   done;
  logic               err;
  logic               mem_rdy;
  logic [1:0]         arx;
  logic               ecx;
  logic               wrx;
  logic               astb;
  logic               rd;
  logic               wr;

  modport master (
    input  req, op, mem_rdy,
    output grant, done, err, arx, ecx, wrx, astb, rd, wr
  );

  modport slave (
    output req, op, mem_rdy,
    input  grant, done, err, arx, ecx, wrx, astb, rd, wr
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin external bus arbiter: grants one channel at a time, runs the
// address/transfer/latch sequence on the busio register file and memory
// strobes, times out on a silent memory and tracks block-transfer bursts so
// that consecutive same-direction block words skip the address phase.
module bus_arbiter_rr #(
  parameter int NCHAN     = 2,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 15
) (
  input logic              clk,
  input logic              reset,
  bus_arbiter_rr_if.master bus
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ARX_ADDR  = 2'd0;
  localparam logic [1:0] ARX_CMD   = 2'd1;
  localparam logic [1:0] ARX_RDATA = 2'd2;
  localparam logic [1:0] ARX_WDATA = 2'd3;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_FETCH = 4'd8;
  localparam logic [3:0] OP_DRD   = 4'd9;
  localparam logic [3:0] OP_DWR   = 4'd10;
  localparam logic [3:0] OP_BTRWR = 4'd12;
  localparam logic [3:0] OP_BTRRD = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_XFER  = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic op_is_read(input logic [3:0] op);
    return (op == OP_FETCH) || (op == OP_DRD) || (op == OP_BTRRD);
  endfunction

  function automatic logic op_is_write(input logic [3:0] op);
    return (op == OP_DWR) || (op == OP_BTRWR);
  endfunction

  function automatic logic op_is_batch(input logic [3:0] op);
    return (op == OP_BTRWR) || (op == OP_BTRRD);
  endfunction

  function automatic logic [1:0] xfer_arx(input logic [3:0] op);
    return (op == OP_FETCH) ? ARX_CMD : (op_is_read(op) ? ARX_RDATA : ARX_WDATA);
  endfunction

  state_t           state_r, state_s;
  logic [NCHAN-1:0] grant_r, grant_s;
  logic [NCHAN-1:0] done_r, done_s;
  logic [NCHAN-1:0] batch_r, batch_s;
  logic [CW-1:0]    owner_r, owner_s;
  logic [CW-1:0]    ptr_r, ptr_s;
  logic [CW-1:0]    pick_s;
  logic [3:0]       cur_op_r, cur_op_s;
  logic [TW-1:0]    wait_r, wait_s;
  logic [BW-1:0]    burst_r [NCHAN];
  logic [BW-1:0]    burst_s [NCHAN];
  logic [3:0]       last_op_r [NCHAN];
  logic [3:0]       last_op_s [NCHAN];
  logic [BW-1:0]    cnt_s;
  logic [1:0]       arx_r, arx_s;
  logic             err_r, err_s;
  logic             ecx_r, ecx_s, wrx_r, wrx_s, astb_r, astb_s, rd_r, rd_s, wr_r, wr_s;
  logic             found_s, fin_s, fail_s;
  int               idx_s;

  // Next state, arbitration, burst bookkeeping and next values of all outputs
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    owner_s   = owner_r;
    ptr_s     = ptr_r;
    cur_op_s  = cur_op_r;
    wait_s    = wait_r;
    batch_s   = batch_r;
    burst_s   = burst_r;
    last_op_s = last_op_r;
    cnt_s     = {BW{1'b0}};
    fin_s     = 1'b0;
    fail_s    = 1'b0;
    found_s   = 1'b0;
    pick_s    = {CW{1'b0}};
    idx_s     = 0;
    done_s    = {NCHAN{1'b0}};
    err_s     = 1'b0;
    arx_s     = ARX_RDATA;
    ecx_s     = 1'b0;
    wrx_s     = 1'b0;
    astb_s    = 1'b0;
    rd_s      = 1'b0;
    wr_s      = 1'b0;

    // Scan downward from the farthest offset so the nearest requester at or
    // after the pointer is the last (winning) assignment.
    for (int k = NCHAN - 1; k >= 0; k--) begin
      idx_s   = (int'(ptr_r) + k) % NCHAN;
      found_s = found_s | bus.req[idx_s];
      pick_s  = bus.req[idx_s] ? CW'(idx_s) : pick_s;
    end

    case (state_r)
      S_IDLE: begin
        // IDLE first registers a grant, then decodes the owner's opcode.
        if (grant_r == {NCHAN{1'b0}}) begin
          if (found_s) begin
            grant_s  = NCHAN'(1'b1) << pick_s;
            owner_s  = pick_s;
            cur_op_s = bus.op[4*int'(pick_s) +: 4];
            ptr_s    = (int'(pick_s) == NCHAN - 1) ? {CW{1'b0}} : pick_s + 1'b1;
          end else begin
            grant_s = {NCHAN{1'b0}};
          end
        end else if (op_is_read(cur_op_r) || op_is_write(cur_op_r)) begin
          wait_s = {TW{1'b0}};
          if (op_is_batch(cur_op_r) && batch_r[owner_r] && (last_op_r[owner_r] == cur_op_r)) begin
            state_s = S_XFER;
          end else begin
            state_s = S_ADDR;
          end
        end else begin
          state_s = S_DONE;
          fin_s   = 1'b1;
          fail_s  = (cur_op_r != OP_NOP);
        end
      end
      S_ADDR: begin
        state_s = S_XFER;
        wait_s  = {TW{1'b0}};
      end
      S_XFER: begin
        if (bus.mem_rdy) begin
          if (op_is_read(cur_op_r)) begin
            state_s = S_LATCH;
          end else begin
            state_s = S_DONE;
            fin_s   = 1'b1;
          end
        end else if (wait_r == TW'(TIMEOUT - 1)) begin
          state_s = S_DONE;
          fin_s   = 1'b1;
          fail_s  = 1'b1;
        end else begin
          wait_s = wait_r + 1'b1;
        end
      end
      S_LATCH: begin
        state_s = S_DONE;
        fin_s   = 1'b1;
      end
      S_DONE: begin
        state_s = S_IDLE;
        grant_s = {NCHAN{1'b0}};
      end
      default: begin
        state_s = S_IDLE;
        grant_s = {NCHAN{1'b0}};
      end
    endcase

    // A successful block word extends the owner's burst; anything else ends it.
    if (fin_s) begin
      last_op_s[owner_r] = cur_op_r;
      if (!fail_s && op_is_batch(cur_op_r)) begin
        cnt_s = ((last_op_r[owner_r] == cur_op_r) ? burst_r[owner_r] : {BW{1'b0}}) + 1'b1;
        if (cnt_s == BW'(BURST_LEN)) begin
          batch_s[owner_r] = 1'b0;
          burst_s[owner_r] = {BW{1'b0}};
        end else begin
          batch_s[owner_r] = 1'b1;
          burst_s[owner_r] = cnt_s;
        end
      end else begin
        batch_s[owner_r] = 1'b0;
        burst_s[owner_r] = {BW{1'b0}};
      end
    end else begin
      cnt_s = {BW{1'b0}};
    end

    case (state_s)
      S_ADDR: begin
        arx_s  = ARX_ADDR;
        ecx_s  = 1'b1;
        astb_s = 1'b1;
      end
      S_XFER: begin
        arx_s = xfer_arx(cur_op_s);
        ecx_s = 1'b1;
        rd_s  = op_is_read(cur_op_s);
        wr_s  = op_is_write(cur_op_s);
      end
      S_LATCH: begin
        arx_s = xfer_arx(cur_op_s);
        ecx_s = 1'b1;
        wrx_s = 1'b1;
      end
      S_DONE: begin
        done_s = grant_s;
        err_s  = fail_s;
      end
      default: begin
        arx_s = ARX_RDATA;
      end
    endcase
  end

  // State, arbitration, burst tracking and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      grant_r  <= {NCHAN{1'b0}};
      owner_r  <= {CW{1'b0}};
      ptr_r    <= {CW{1'b0}};
      cur_op_r <= 4'd0;
      wait_r   <= {TW{1'b0}};
      batch_r  <= {NCHAN{1'b0}};
      for (int i = 0; i < NCHAN; i++) begin
        burst_r[i]   <= {BW{1'b0}};
        last_op_r[i] <= 4'd0;
      end
      done_r   <= {NCHAN{1'b0}};
      err_r    <= 1'b0;
      arx_r    <= ARX_RDATA;
      ecx_r    <= 1'b0;
      wrx_r    <= 1'b0;
      astb_r   <= 1'b0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      owner_r   <= owner_s;
      ptr_r     <= ptr_s;
      cur_op_r  <= cur_op_s;
      wait_r    <= wait_s;
      batch_r   <= batch_s;
      burst_r   <= burst_s;
      last_op_r <= last_op_s;
      done_r    <= done_s;
      err_r     <= err_s;
      arx_r     <= arx_s;
      ecx_r     <= ecx_s;
      wrx_r     <= wrx_s;
      astb_r    <= astb_s;
      rd_r      <= rd_s;
      wr_r      <= wr_s;
    end
  end

  assign bus.grant = grant_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.arx   = arx_r;
  assign bus.ecx   = ecx_r;
  assign bus.wrx   = wrx_r;
  assign bus.astb  = astb_r;
  assign bus.rd    = rd_r;
  assign bus.wr    = wr_r;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr. Each transaction's expected
// cycle-by-cycle bus trace is built from the protocol rules (grant, optional
// address phase, transfer wait, optional latch, done) and compared against
// the outputs sampled on the falling clock edge.
module tb_bus_arbiter_rr;
  localparam int NCHAN     = 2;
  localparam int BURST_LEN = 8;
  localparam int TIMEOUT   = 15;

  typedef logic [2*NCHAN+7:0] vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // Reference state: consecutive successful block words per channel and
  // the opcode of that run; next round-robin start channel.
  int         chain_len [NCHAN];
  logic [3:0] chain_op  [NCHAN];
  int         rr_next;

  bus_arbiter_rr_if #(.NCHAN(NCHAN)) bif ();

  bus_arbiter_rr #(
    .NCHAN    (NCHAN),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t pack(input logic [NCHAN-1:0] g, input logic [NCHAN-1:0] d,
                                input logic e, input logic [1:0] a, input logic [4:0] s);
    return {g, d, e, a, s};
  endfunction

  function automatic vec_t observe();
    return {bif.grant, bif.done, bif.err, bif.arx, bif.ecx, bif.wrx, bif.astb, bif.rd, bif.wr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr_next = 0;
    for (int i = 0; i < NCHAN; i++) begin
      chain_len[i] = 0;
      chain_op[i]  = 4'd0;
    end
  endtask

  // One request on channel ch; delay = XFER cycles with mem_rdy low before it rises.
  task automatic run_txn(input int ch, input logic [3:0] op, input int delay, input bit drop_early);
    vec_t             q[$];
    logic [NCHAN-1:0] g;
    logic [NCHAN-1:0] z;
    bit               mem, rdop, skip, tmo;
    int               nx, first_x, rdy_at;
    logic [1:0]       xa;
    z       = '0;
    g       = z;
    g[ch]   = 1'b1;
    mem     = op inside {4'd8, 4'd9, 4'd10, 4'd12, 4'd13};
    rdop    = op inside {4'd8, 4'd9, 4'd13};
    xa      = (op == 4'd8) ? 2'd1 : (rdop ? 2'd2 : 2'd3);
    skip    = (op == 4'd12 || op == 4'd13) && (chain_op[ch] == op) && ((chain_len[ch] % BURST_LEN) != 0);
    tmo     = mem && (delay >= TIMEOUT);
    nx      = tmo ? TIMEOUT : delay + 1;
    first_x = skip ? 1 : 2;
    rdy_at  = (mem && !tmo) ? first_x + delay : -1;

    q.push_back(pack(g, z, 1'b0, 2'd2, 5'b00000));
    if (mem) begin
      if (!skip) q.push_back(pack(g, z, 1'b0, 2'd0, 5'b10100));
      for (int i = 0; i < nx; i++) q.push_back(pack(g, z, 1'b0, xa, {3'b100, rdop, !rdop}));
      if (rdop && !tmo) q.push_back(pack(g, z, 1'b0, xa, 5'b11000));
      q.push_back(pack(g, g, tmo, 2'd2, 5'b00000));
    end else begin
      q.push_back(pack(g, g, op != 4'd0, 2'd2, 5'b00000));
    end

    bif.op[4*ch +: 4] = op;
    bif.req[ch]       = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check($sformatf("txn ch%0d op%0d dly%0d cyc%0d", ch, op, delay, i), observe(), q[i]);
      if (i == rdy_at) bif.mem_rdy = 1'b1;
      else if (mem && i >= first_x && i < first_x + nx) bif.mem_rdy = 1'b0;
      else bif.mem_rdy = 1'($urandom_range(0, 1));
      if ((drop_early && i == 1) || i == q.size() - 1) begin
        bif.req[ch]       = 1'b0;
        bif.op[4*ch +: 4] = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    bif.mem_rdy = 1'b0;
    check($sformatf("idle after ch%0d op%0d", ch, op), observe(), pack(z, z, 1'b0, 2'd2, 5'b00000));

    if ((op == 4'd12 || op == 4'd13) && !tmo) begin
      chain_len[ch] = (chain_op[ch] == op) ? chain_len[ch] + 1 : 1;
      chain_op[ch]  = op;
    end else begin
      chain_len[ch] = 0;
    end
    rr_next = (ch + 1) % NCHAN;
  endtask

  logic [3:0]       op_tab [10] = '{4'd13, 4'd13, 4'd13, 4'd12, 4'd12, 4'd9, 4'd8, 4'd10, 4'd0, 4'd14};
  logic [NCHAN-1:0] exp_g;
  logic [NCHAN-1:0] zero_g;

  initial begin
    zero_g      = '0;
    bif.req     = '0;
    bif.op      = '0;
    bif.mem_rdy = 1'b0;
    model_reset();

    // Reset state, then release
    repeat (3) @(negedge clk);
    check("reset state", observe(), pack(zero_g, zero_g, 1'b0, 2'd2, 5'b00000));
    reset = 1'b1;
    @(negedge clk);
    check("after release", observe(), pack(zero_g, zero_g, 1'b0, 2'd2, 5'b00000));

    // Single read with immediate ready; write with ready after 3 waits
    run_txn(0, 4'd9, 0, 1'b0);
    run_txn(1, 4'd10, 3, 1'b0);

    // Both channels fetching continuously: grants alternate
    for (int c = 0; c < NCHAN; c++) bif.op[4*c +: 4] = 4'd8;
    bif.mem_rdy = 1'b1;
    bif.req     = '1;
    for (int t = 0; t < 4; t++) begin
      exp_g          = '0;
      exp_g[rr_next] = 1'b1;
      for (int n = 0; n < 20 && bif.grant == zero_g; n++) @(negedge clk);
      check($sformatf("rr grant %0d", t), bif.grant, exp_g);
      rr_next = (rr_next + 1) % NCHAN;
      for (int n = 0; n < 20 && bif.done == zero_g; n++) begin
        if (bif.rd) check("fetch arx", bif.arx, 2'd1);
        @(negedge clk);
      end
      check($sformatf("rr done %0d", t), bif.done, exp_g);
      @(negedge clk);
    end
    bif.req     = '0;
    bif.mem_rdy = 1'b0;
    for (int c = 0; c < NCHAN; c++) chain_len[c] = 0;
    @(negedge clk);
    check("idle after rr", observe(), pack(zero_g, zero_g, 1'b0, 2'd2, 5'b00000));

    // Ten block reads: address on words 1 and 9 only
    for (int w = 0; w < 10; w++) run_txn(0, 4'd13, 0, 1'b0);

    // Timeouts, then a block read must resend its address
    run_txn(0, 4'd9, TIMEOUT + 5, 1'b0);
    run_txn(0, 4'd13, 0, 1'b0);
    run_txn(0, 4'd13, 99, 1'b0);
    run_txn(0, 4'd13, 0, 1'b0);
    run_txn(0, 4'd13, TIMEOUT - 1, 1'b0);

    // Unsupported opcode and no-op
    run_txn(1, 4'd14, 0, 1'b0);
    run_txn(1, 4'd0, 0, 1'b0);

    // Randomised mix, including early request drop and timeouts
    for (int t = 0; t < 40; t++) begin
      run_txn(int'($urandom_range(0, NCHAN - 1)), op_tab[$urandom_range(0, 9)],
              ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    // Reset during a transfer drops strobes and grant immediately
    bif.op[3:0] = 4'd9;
    bif.mem_rdy = 1'b0;
    bif.req[0]  = 1'b1;
    for (int n = 0; n < 10 && !bif.rd; n++) @(negedge clk);
    check("rd before reset", bif.rd, 1'b1);
    #2 reset = 1'b0;
    #1 check("reset mid xfer", observe(), pack(zero_g, zero_g, 1'b0, 2'd2, 5'b00000));
    bif.req = '0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("idle after reset", observe(), pack(zero_g, zero_g, 1'b0, 2'd2, 5'b00000));
    run_txn(0, 4'd13, 0, 1'b0);
    run_txn(0, 4'd13, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
